ddr3_avl_arbiter: RTL and testbench

// - Shares the single DDR3 Avalon master (AVL) between two clients: client 0 = block loader (reads),

---
 rtl/ddr3_avl_arbiter_if.sv | 25 ++
 rtl/ddr3_avl_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_ddr3_avl_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_avl_arbiter_if.sv
// Avalon master bundle between the arbiter and the DDR3 controller.
interface ddr3_avl_arbiter_if #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 128
);
  logic [ADDR_W-1:0] avl_address;
  logic [DATA_W-1:0] avl_writedata;
  logic              avl_read;
  logic              avl_write;
  logic              avl_burstbegin;
  logic              avl_wait_request_n;
  logic [DATA_W-1:0] avl_readdata;
  logic              avl_readdata_valid;
  logic              local_init_done;

  modport master (
    output avl_address, avl_writedata, avl_read, avl_write, avl_burstbegin,
    input  avl_wait_request_n, avl_readdata, avl_readdata_valid, local_init_done
  );

  modport slave (
    input  avl_address, avl_writedata, avl_read, avl_write, avl_burstbegin,
    output avl_wait_request_n, avl_readdata, avl_readdata_valid, local_init_done
  );
endinterface

// File: rtl/ddr3_avl_arbiter.sv
// Two-client arbiter sharing one DDR3 Avalon master; grants per burst quantum and routes read data
// back to the owner. Optional command watchdog is enabled by defining ARB_WDOG_EN.
module ddr3_avl_arbiter #(
  parameter int ADDR_W      = 26,
  parameter int DATA_W      = 128,
  parameter int QUANTUM     = 16,
  parameter int IDLE_HOLD   = 12,
  parameter int MAX_OUTST   = 8,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                   iCLK,
  input  logic                   reset,
  input  logic [1:0]             c_read,
  input  logic [1:0]             c_write,
  input  logic [1:0][ADDR_W-1:0] c_address,
  input  logic [1:0][DATA_W-1:0] c_writedata,
  output logic [1:0]             c_wait_request_n,
  output logic [DATA_W-1:0]      c_readdata,
  output logic [1:0]             c_readdata_valid,
  output logic [1:0]             grant,
  output logic                   wdog_err,
  ddr3_avl_arbiter_if.master     avl
);

  localparam int BW = $clog2(QUANTUM + 1);
  localparam int IW = $clog2(IDLE_HOLD + 1);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam logic [BW-1:0] BEATS_MAX = BW'(QUANTUM);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_HOLD);
  localparam logic [OW-1:0] OUTST_MAX = OW'(MAX_OUTST);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [1:0]      grant_r, grant_s;
  logic            last_r, last_s;
  logic [BW-1:0]   beats_r, beats_s;
  logic [IW-1:0]   idle_r, idle_s;
  logic [OW-1:0]   outst_r;

  logic            own_idx_s;
  logic [1:0]      req_s;
  logic            pick_s;
  logic            own_req_s;
  logic            oth_req_s;
  logic            release_s;
  logic            mask_s;
  logic            accept_s;
  logic            rd_accept_s;
  logic            rd_ret_s;
  logic            wdog_trip_s;

  // Request decode and the conditions that end the current grant.
  always_comb begin
    own_idx_s = grant_r[1];
    req_s     = c_read | c_write;
    pick_s    = (req_s == 2'b11) ? ~last_r : req_s[1];
    own_req_s = req_s[own_idx_s];
    oth_req_s = req_s[~own_idx_s];
    release_s = ((beats_r == BEATS_MAX) & oth_req_s) | (idle_r == IDLE_MAX) |
                ~avl.local_init_done | wdog_trip_s;
    // Commands are blocked outside OWN, with the read window full, and on the release cycle.
    mask_s    = (state_r != ST_OWN) | (outst_r == OUTST_MAX) | release_s;
  end

  // Command path to the controller, steered from the registered owner.
  always_comb begin
    avl.avl_address   = '0;
    avl.avl_writedata = '0;
    avl.avl_read      = 1'b0;
    avl.avl_write     = 1'b0;
    c_wait_request_n  = 2'b00;
    if (state_r == ST_OWN) begin
      avl.avl_address               = c_address[own_idx_s];
      avl.avl_writedata             = c_writedata[own_idx_s];
      avl.avl_read                  = c_read[own_idx_s] & ~mask_s;
      avl.avl_write                 = c_write[own_idx_s] & ~mask_s;
      c_wait_request_n[own_idx_s]   = avl.avl_wait_request_n & ~mask_s;
    end else begin
      avl.avl_read  = 1'b0;
      avl.avl_write = 1'b0;
    end
  end

  assign avl.avl_burstbegin = avl.avl_read | avl.avl_write;
  assign accept_s    = (avl.avl_read | avl.avl_write) & avl.avl_wait_request_n;
  assign rd_accept_s = avl.avl_read & avl.avl_wait_request_n;
  // Returns with nothing outstanding belong to an abandoned transfer and are dropped.
  assign rd_ret_s    = avl.avl_readdata_valid & (outst_r != {OW{1'b0}});
  assign c_readdata  = avl.avl_readdata;
  assign grant       = grant_r;

  // Read-data strobe goes only to the client that owns the outstanding reads.
  always_comb begin
    c_readdata_valid            = 2'b00;
    c_readdata_valid[grant_r[1]] = rd_ret_s;
  end

  // Arbitration next-state and counter updates.
  always_comb begin
    state_s = state_r;
    grant_s = grant_r;
    last_s  = last_r;
    beats_s = beats_r;
    idle_s  = idle_r;
    case (state_r)
      ST_IDLE: begin
        if (avl.local_init_done && (req_s != 2'b00)) begin
          grant_s = pick_s ? 2'b10 : 2'b01;
          last_s  = pick_s;
          beats_s = '0;
          idle_s  = '0;
          state_s = ST_OWN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_OWN: begin
        if (release_s) begin
          state_s = ST_DRAIN;
        end else begin
          if (beats_r == BEATS_MAX) begin
            beats_s = {{(BW-1){1'b0}}, accept_s};
          end else if (accept_s) begin
            beats_s = beats_r + BW'(1);
          end else begin
            beats_s = beats_r;
          end
          if (own_req_s) begin
            idle_s = '0;
          end else if (idle_r != IDLE_MAX) begin
            idle_s = idle_r + IW'(1);
          end else begin
            idle_s = idle_r;
          end
        end
      end
      ST_DRAIN: begin
        if (outst_r == {OW{1'b0}}) begin
          grant_s = 2'b00;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        grant_s = 2'b00;
        state_s = ST_IDLE;
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge iCLK) begin
    if (reset) begin
      state_r <= ST_IDLE;
      grant_r <= 2'b00;
      last_r  <= 1'b1;
      beats_r <= '0;
      idle_r  <= '0;
    end else begin
      state_r <= state_s;
      grant_r <= grant_s;
      last_r  <= last_s;
      beats_r <= beats_s;
      idle_r  <= idle_s;
    end
  end

  // Outstanding-read counter; simultaneous issue and return cancel out.
  always_ff @(posedge iCLK) begin
    if (reset) begin
      outst_r <= '0;
    end else if (wdog_trip_s) begin
      outst_r <= '0;
    end else if (rd_accept_s && !rd_ret_s) begin
      outst_r <= outst_r + OW'(1);
    end else if (!rd_accept_s && rd_ret_s) begin
      outst_r <= outst_r - OW'(1);
    end else begin
      outst_r <= outst_r;
    end
  end

`ifdef ARB_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WW-1:0] WDOG_MAX = WW'(WDOG_CYCLES);

  logic [WW-1:0] wdog_cnt_r;
  logic          wdog_err_r;
  logic          stall_s;

  assign stall_s     = (avl.avl_read | avl.avl_write) & ~avl.avl_wait_request_n;
  assign wdog_trip_s = (wdog_cnt_r == WDOG_MAX);
  assign wdog_err    = wdog_err_r;

  // Counts consecutive cycles a presented command is held off by the controller.
  always_ff @(posedge iCLK) begin
    if (reset) begin
      wdog_cnt_r <= '0;
      wdog_err_r <= 1'b0;
    end else begin
      if (stall_s && (wdog_cnt_r != WDOG_MAX)) begin
        wdog_cnt_r <= wdog_cnt_r + WW'(1);
      end else if (stall_s) begin
        wdog_cnt_r <= wdog_cnt_r;
      end else begin
        wdog_cnt_r <= '0;
      end
      wdog_err_r <= wdog_err_r | wdog_trip_s;
    end
  end
`else
  assign wdog_trip_s = 1'b0;
  assign wdog_err    = 1'b0;
`endif

endmodule

// File: tb/tb_ddr3_avl_arbiter.sv
// Directed bench for ddr3_avl_arbiter: reset, init gating, quantum alternation, read window,
// idle release, reset during drain, and watchdog behaviour.
module tb_ddr3_avl_arbiter;

  logic               iCLK;
  logic               reset;
  logic [1:0]         c_read;
  logic [1:0]         c_write;
  logic [1:0][25:0]   c_address;
  logic [1:0][127:0]  c_writedata;
  logic [1:0]         c_wait_request_n;
  logic [127:0]       c_readdata;
  logic [1:0]         c_readdata_valid;
  logic [1:0]         grant;
  logic               wdog_err;

  int tests = 0;
  int fails = 0;
  int seq [0:47];
  int n;
  int both;
  int cnt;

  ddr3_avl_arbiter_if #(.ADDR_W(26), .DATA_W(128)) avl_if ();

  ddr3_avl_arbiter dut (
    .iCLK             (iCLK),
    .reset            (reset),
    .c_read           (c_read),
    .c_write          (c_write),
    .c_address        (c_address),
    .c_writedata      (c_writedata),
    .c_wait_request_n (c_wait_request_n),
    .c_readdata       (c_readdata),
    .c_readdata_valid (c_readdata_valid),
    .grant            (grant),
    .wdog_err         (wdog_err),
    .avl              (avl_if.master)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic tick();
    @(posedge iCLK);
    #2;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    c_read = 2'b00;
    c_write = 2'b00;
    c_address = '0;
    c_writedata = '0;
    avl_if.avl_wait_request_n = 1'b0;
    avl_if.avl_readdata = '0;
    avl_if.avl_readdata_valid = 1'b0;
    avl_if.local_init_done = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_avl_read", avl_if.avl_read, 1'b0);
    chk("rst_avl_write", avl_if.avl_write, 1'b0);
    chk("rst_burstbegin", avl_if.avl_burstbegin, 1'b0);
    chk("rst_c_wait", c_wait_request_n, 2'b00);
    chk("rst_c_rdv", c_readdata_valid, 2'b00);
    chk("rst_wdog", wdog_err, 1'b0);

    // No grant while the controller is still initialising.
    c_write = 2'b10;
    avl_if.avl_wait_request_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(); #1;
      chk("noinit_grant", grant, 2'b00);
      chk("noinit_write", avl_if.avl_write, 1'b0);
    end

    // Single write from client 1, then idle release after IDLE_HOLD cycles.
    c_address[1] = 26'h100;
    c_writedata[1] = 128'hCAFE_0001;
    avl_if.local_init_done = 1'b1;
    tick(); #1;
    chk("w1_grant", grant, 2'b10);
    chk("w1_avl_write", avl_if.avl_write, 1'b1);
    chk("w1_addr", avl_if.avl_address, 26'h100);
    chk("w1_wdata", avl_if.avl_writedata, 128'hCAFE_0001);
    chk("w1_c_wait", c_wait_request_n, 2'b10);
    chk("w1_burstbegin", avl_if.avl_burstbegin, 1'b1);
    tick();
    c_write = 2'b00;
    #1;
    chk("w1_done_write", avl_if.avl_write, 1'b0);
    repeat (11) tick();
    #1;
    chk("idle11_c_wait", c_wait_request_n, 2'b10);
    chk("idle11_grant", grant, 2'b10);
    tick(); #1;
    chk("idle12_c_wait", c_wait_request_n, 2'b00);
    chk("idle12_grant", grant, 2'b10);
    tick(); #1;
    chk("drain_grant", grant, 2'b10);
    tick(); #1;
    chk("idle_release_grant", grant, 2'b00);

    // Both clients stream writes: owner alternates every QUANTUM accepts, client 0 first.
    c_address[0] = 26'h300;
    c_writedata[0] = 128'h5A5A;
    c_write = 2'b11;
    n = 0;
    both = 0;
    for (int cyc = 0; cyc < 200 && n < 48; cyc++) begin
      tick(); #1;
      if (c_wait_request_n == 2'b11) begin
        both++;
      end else if (c_wait_request_n[0]) begin
        seq[n] = 0;
        n++;
      end else if (c_wait_request_n[1]) begin
        seq[n] = 1;
        n++;
      end
    end
    tick();
    c_write = 2'b00;
    chk("stream_total", n, 48);
    chk("stream_both", both, 0);
    for (int r = 0; r < 3; r++) begin
      cnt = 0;
      for (int i = 16 * r; i < 16 * r + 16; i++) begin
        if (seq[i] == (r % 2)) cnt++;
      end
      chk("quantum_run", cnt, 16);
    end
    for (int k = 0; k < 40 && grant != 2'b00; k++) tick();
    #1;
    chk("stream_idle_grant", grant, 2'b00);

    // Client 0 fills the read window; the ninth read is held off.
    c_address[0] = 26'h400;
    c_read = 2'b01;
    n = 0;
    for (int cyc = 0; cyc < 20 && n < 8; cyc++) begin
      tick(); #1;
      if (c_wait_request_n[0]) n++;
    end
    chk("rd8_accepts", n, 8);
    tick(); #1;
    chk("rd9_c_wait", c_wait_request_n, 2'b00);
    chk("rd9_avl_read", avl_if.avl_read, 1'b0);
    chk("rd9_grant", grant, 2'b01);
    repeat (2) tick();
    #1;
    chk("rd9_still_stalled", c_wait_request_n, 2'b00);
    c_read = 2'b00;
    c_address[1] = 26'h200;
    c_write = 2'b10;
    repeat (16) tick();
    #1;
    chk("drain_hold_grant", grant, 2'b01);
    chk("drain_hold_write", avl_if.avl_write, 1'b0);
    chk("drain_hold_c_wait", c_wait_request_n, 2'b00);
    for (int k = 0; k < 8; k++) begin
      avl_if.avl_readdata = 128'h1000 + 128'(k);
      avl_if.avl_readdata_valid = 1'b1;
      #1;
      chk("rdv_owner", c_readdata_valid, 2'b01);
      chk("rdv_data", c_readdata, 128'h1000 + 128'(k));
      chk("rdv_grant", grant, 2'b01);
      tick();
    end
    avl_if.avl_readdata_valid = 1'b0;
    #1;
    chk("rdv_off", c_readdata_valid, 2'b00);
    for (int k = 0; k < 10 && grant != 2'b10; k++) tick();
    #1;
    chk("handover_grant", grant, 2'b10);
    chk("handover_c_wait", c_wait_request_n, 2'b10);
    chk("handover_addr", avl_if.avl_address, 26'h200);
    tick();
    c_write = 2'b00;

    // Reset while draining three outstanding reads; late returns are dropped.
    for (int k = 0; k < 30 && grant != 2'b00; k++) tick();
    c_address[0] = 26'h500;
    c_read = 2'b01;
    n = 0;
    for (int cyc = 0; cyc < 10 && n < 3; cyc++) begin
      tick(); #1;
      if (c_wait_request_n[0]) n++;
    end
    tick();
    c_read = 2'b00;
    repeat (15) tick();
    #1;
    chk("pre_reset_grant", grant, 2'b01);
    chk("pre_reset_read", avl_if.avl_read, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("mid_drain_reset_grant", grant, 2'b00);
    for (int k = 0; k < 3; k++) begin
      avl_if.avl_readdata = 128'hDEAD;
      avl_if.avl_readdata_valid = 1'b1;
      #1;
      chk("straggler_dropped", c_readdata_valid, 2'b00);
      tick();
    end
    avl_if.avl_readdata_valid = 1'b0;
    c_address[1] = 26'h600;
    c_read = 2'b10;
    tick(); #1;
    chk("post_reset_grant", grant, 2'b10);
    chk("post_reset_read", avl_if.avl_read, 1'b1);
    tick();
    c_read = 2'b00;
    avl_if.avl_readdata = 128'hBEEF;
    avl_if.avl_readdata_valid = 1'b1;
    #1;
    chk("post_reset_rdv", c_readdata_valid, 2'b10);
    tick();
    avl_if.avl_readdata_valid = 1'b0;

    // Controller holds off a command indefinitely.
    for (int k = 0; k < 30 && grant != 2'b00; k++) tick();
    c_address[0] = 26'h700;
    c_write = 2'b01;
    avl_if.avl_wait_request_n = 1'b0;
`ifdef ARB_WDOG_EN
    for (int k = 0; k < 1100 && wdog_err != 1'b1; k++) tick();
    #1;
    chk("wdog_err_set", wdog_err, 1'b1);
    chk("wdog_drain_grant", grant, 2'b01);
    chk("wdog_masked", avl_if.avl_write, 1'b0);
    c_write = 2'b00;
    tick(); #1;
    chk("wdog_idle_grant", grant, 2'b00);
    chk("wdog_sticky", wdog_err, 1'b1);
`else
    repeat (50) tick();
    #1;
    chk("nowdog_err", wdog_err, 1'b0);
    chk("nowdog_grant", grant, 2'b01);
    chk("nowdog_write_held", avl_if.avl_write, 1'b1);
    chk("nowdog_c_wait", c_wait_request_n, 2'b00);
    c_write = 2'b00;
`endif
    avl_if.avl_wait_request_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
